id_scoreboard: RTL and testbench
================================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameter NUM_RP, default 2, number of operand read ports.
REQ-002 Parameter NUM_FWD, default 3, number of forwarding sources, index 0 = youngest (EXE), NUM_FWD-1 = oldest (WB).
REQ-003 Parameter DATA_W, default 32, operand width; AW fixed at 5 (32 GPRs, r0 hard-zero).
REQ-004 Parameter CNT_W, default 2, per-register pending-write counter width.
REQ-005 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-006 rp_en  input  NUM_RP  per-port operand-needed flag.
REQ-007 rp_addr  input  NUM_RP*5  per-port source register.
REQ-008 rf_rdata  input  NUM_RP*DATA_W  regfile read data per port.
REQ-009 fwd_we  input  NUM_FWD  source holds a valid GPR-writing instruction.
REQ-010 fwd_dest  input  NUM_FWD*5  source destination register.
REQ-011 fwd_ok  input  NUM_FWD  source result available this cycle (0 = load/div still busy).
REQ-012 fwd_data  input  NUM_FWD*DATA_W  source result.
REQ-013 iss_fire  input  1  decode->EXE handshake completes this cycle.
REQ-014 iss_we, iss_dest  input  1, 5  issuing instruction writes GPR iss_dest.
REQ-015 ret_we, ret_dest  input  1, 5  write-back commits to GPR ret_dest this cycle.
REQ-016 cxl_we, cxl_dest  input  1, 5  an issued, uncommitted writer is squashed this cycle.
REQ-017 rp_data  output  NUM_RP*DATA_W  resolved operand per port.
REQ-018 ds_stall  output  1  decode must not issue this cycle.
REQ-019 sb_err  output  1  sticky counter over/underflow flag.

Function
REQ-020 Scoreboard holds cnt[1..31], CNT_W bits each; cnt[0] constant 0.
REQ-021 Per register r!=0, next cnt = cnt + inc - dec, inc = iss_fire&iss_we&(iss_dest==r), dec = number of (ret, cxl) ports matching r with we set (0..2).
REQ-022 Simultaneous inc and dec on the same register net per REQ-021; counter updates visible next cycle.
REQ-023 Decrement below 0 clamps at 0 and sets sb_err; increment at all-ones holds value and sets sb_err.
REQ-024 Operand resolution per port p with rp_en=1, addr!=0: first matching fwd source in index order (0 first) supplies fwd_data; else rf_rdata.
REQ-025 Port stall condition: rp_en & addr!=0 & (first match exists with fwd_ok=0, or no match but cnt[addr]!=0 and not (ret_we & ret_dest==addr)).
REQ-026 ds_stall = OR of port stall conditions, OR (iss_we & iss_dest!=0 & cnt[iss_dest] all-ones).
REQ-027 addr==0 or rp_en=0: rp_data = 0 / rf_rdata respectively, never stalls.
REQ-028 rp_data and ds_stall combinational from inputs and current cnt; zero-cycle latency.
REQ-029 iss_fire while ds_stall=1 is a protocol error: counter still updates, sb_err set.

Reset
REQ-030 reset clears all cnt to 0 and sb_err to 0; reset overrides all same-cycle iss/ret/cxl events.
REQ-031 Outputs after reset: ds_stall=0 unless iss-saturation impossible (always 0 with empty board), rp_data per REQ-024.

Structure
REQ-032 Shared package holds AW=5, GPR count 32, default DATA_W and CNT_W, and fwd index constants FWD_ES=0, FWD_MS=1, FWD_WS=2.
REQ-033 One sub-module sb_port_resolve (single-port priority match + stall), instantiated NUM_RP times; counters live in the top.

Verification
REQ-034 Reset then rp_addr={5,3}, no fwd, rf_rdata={0x11,0x22} -> rp_data={0x11,0x22}, ds_stall=0.
REQ-035 fwd0 and fwd2 both dest r5, fwd_ok=1, data 0xA/0xC -> port reading r5 gets 0xA.
REQ-036 fwd0 dest r5, fwd_ok=0 (load), fwd1 dest r5 ok -> ds_stall=1; next cycle fwd_ok=1 -> ds_stall=0, data from fwd0.
REQ-037 Issue div to r7 (cnt[7]=1), leaves fwd window; read r7 -> stall each cycle until ret r7 cycle where fwd2 supplies data, stall drops; cnt[7]=0 next cycle.
REQ-038 Same-cycle iss r9 and ret r9 with cnt[9]=1 -> cnt[9] stays 1; cxl r9 next -> 0; further cxl r9 -> stays 0, sb_err=1.
REQ-039 CNT_W=2: three issues to r4 then fourth attempt -> ds_stall=1; reset mid-sequence -> cnt cleared, sb_err=0.

Source files
------------

// File: rtl/id_scoreboard_pkg.sv
// Shared constants and types for the decode-stage operand scoreboard.
package id_scoreboard_pkg;

   localparam int AW         = 5;
   localparam int NUM_GPR    = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 2;

   // Forwarding source indices, youngest first.
   localparam int FWD_ES = 0;
   localparam int FWD_MS = 1;
   localparam int FWD_WS = 2;

   typedef logic [AW-1:0] gpr_t;

endpackage

// File: rtl/id_scoreboard_sb_port_resolve.sv
// Single read port: priority match over the forwarding sources plus the stall
// decision for that port. Register-file fallback covers the no-match case.
module sb_port_resolve
   import id_scoreboard_pkg::*;
#(
   parameter int NUM_FWD = 3,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      en,
   input  gpr_t                      addr,
   input  logic [DATA_W-1:0]         rf_rdata,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*AW-1:0]     fwd_dest,
   input  logic [NUM_FWD-1:0]        fwd_ok,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   input  logic                      busy,
   input  logic                      ret_hit,
   output logic [DATA_W-1:0]         data,
   output logic                      stall
);

   logic              hit;
   logic              hit_ok;
   logic [DATA_W-1:0] hit_data;

   // Scan oldest to youngest so the lowest-index match is the one that sticks.
   always_comb begin
      hit      = 1'b0;
      hit_ok   = 1'b0;
      hit_data = '0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_we[i] && (fwd_dest[i*AW +: AW] == addr)) begin
            hit      = 1'b1;
            hit_ok   = fwd_ok[i];
            hit_data = fwd_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // r0 reads as zero; a retiring write to the register releases the stall
   // because the matching WB source is expected to be on the bypass.
   always_comb begin
      data  = rf_rdata;
      stall = 1'b0;
      if (en) begin
         if (addr == '0) begin
            data = '0;
         end else if (hit) begin
            data  = hit_data;
            stall = !hit_ok;
         end else begin
            stall = busy && !ret_hit;
         end
      end
   end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage GPR scoreboard: per-register pending-write counters, operand
// bypass selection per read port and the decode stall.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int NUM_RP  = 2,
   parameter int NUM_FWD = 3,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_RP-1:0]         rp_en,
   input  logic [NUM_RP*AW-1:0]      rp_addr,
   input  logic [NUM_RP*DATA_W-1:0]  rf_rdata,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*AW-1:0]     fwd_dest,
   input  logic [NUM_FWD-1:0]        fwd_ok,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   input  logic                      iss_fire,
   input  logic                      iss_we,
   input  gpr_t                      iss_dest,
   input  logic                      ret_we,
   input  gpr_t                      ret_dest,
   input  logic                      cxl_we,
   input  gpr_t                      cxl_dest,
   output logic [NUM_RP*DATA_W-1:0]  rp_data,
   output logic                      ds_stall,
   output logic                      sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]   cnt     [NUM_GPR];
   logic [CNT_W-1:0]   cnt_nxt [NUM_GPR];
   logic [NUM_GPR-1:0] cnt_err;
   logic [NUM_RP-1:0]  port_stall;
   logic               iss_sat;

   // Returns {error, next}: net change clamped into [0, CNT_MAX].
   function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cur,
                                               input logic inc,
                                               input logic [1:0] dec);
      logic [CNT_W+1:0] up;
      logic [CNT_W+1:0] down;
      logic [CNT_W+1:0] diff;
      up   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
      down = {{CNT_W{1'b0}}, dec};
      diff = up - down;
      if (up < down)
         cnt_step = {1'b1, {CNT_W{1'b0}}};
      else if (diff > {2'b00, CNT_MAX})
         cnt_step = {1'b1, CNT_MAX};
      else
         cnt_step = {1'b0, diff[CNT_W-1:0]};
   endfunction

   // Next count per register; r0 is pinned at zero and never flags.
   always_comb begin
      cnt_err = '0;
      for (int r = 0; r < NUM_GPR; r++) begin
         cnt_nxt[r] = '0;
         if (r != 0) begin
            {cnt_err[r], cnt_nxt[r]} = cnt_step(cnt[r],
               iss_fire && iss_we && (iss_dest == AW'(r)),
               2'(ret_we && (ret_dest == AW'(r))) + 2'(cxl_we && (cxl_dest == AW'(r))));
         end
      end
   end

   // Counter bank and sticky error; reset wins over any same-cycle event.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_GPR; r++) cnt[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_GPR; r++) cnt[r] <= cnt_nxt[r];
         sb_err <= sb_err | (|cnt_err) | (iss_fire & ds_stall);
      end
   end

   for (genvar p = 0; p < NUM_RP; p++) begin : g_port
      sb_port_resolve #(
         .NUM_FWD (NUM_FWD),
         .DATA_W  (DATA_W)
      ) u_resolve (
         .en       (rp_en[p]),
         .addr     (rp_addr[p*AW +: AW]),
         .rf_rdata (rf_rdata[p*DATA_W +: DATA_W]),
         .fwd_we   (fwd_we),
         .fwd_dest (fwd_dest),
         .fwd_ok   (fwd_ok),
         .fwd_data (fwd_data),
         .busy     (cnt[rp_addr[p*AW +: AW]] != '0),
         .ret_hit  (ret_we && (ret_dest == rp_addr[p*AW +: AW])),
         .data     (rp_data[p*DATA_W +: DATA_W]),
         .stall    (port_stall[p])
      );
   end

   // Stall on any unresolved operand, or when the issuing writer would saturate.
   always_comb begin
      iss_sat  = iss_we && (iss_dest != '0) && (cnt[iss_dest] == CNT_MAX);
      ds_stall = (|port_stall) || iss_sat;
   end

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios with constant expectations,
// then a randomized run against a queue-free array model of the scoreboard.
module tb_id_scoreboard;

   localparam int NUM_RP  = 2;
   localparam int NUM_FWD = 3;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 2;
   localparam int MAXC    = (1 << CNT_W) - 1;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_RP-1:0]         rp_en;
   logic [NUM_RP*5-1:0]       rp_addr;
   logic [NUM_RP*DATA_W-1:0]  rf_rdata;
   logic [NUM_FWD-1:0]        fwd_we;
   logic [NUM_FWD*5-1:0]      fwd_dest;
   logic [NUM_FWD-1:0]        fwd_ok;
   logic [NUM_FWD*DATA_W-1:0] fwd_data;
   logic                      iss_fire, iss_we, ret_we, cxl_we;
   logic [4:0]                iss_dest, ret_dest, cxl_dest;
   logic [NUM_RP*DATA_W-1:0]  rp_data;
   logic                      ds_stall;
   logic                      sb_err;

   int checks   = 0;
   int failures = 0;

   int                cnt_m [32];
   bit                err_m;
   logic [DATA_W-1:0] exp_data [NUM_RP];
   bit                exp_stall;

   id_scoreboard #(
      .NUM_RP (NUM_RP), .NUM_FWD (NUM_FWD), .DATA_W (DATA_W), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .reset (reset),
      .rp_en (rp_en), .rp_addr (rp_addr), .rf_rdata (rf_rdata),
      .fwd_we (fwd_we), .fwd_dest (fwd_dest), .fwd_ok (fwd_ok), .fwd_data (fwd_data),
      .iss_fire (iss_fire), .iss_we (iss_we), .iss_dest (iss_dest),
      .ret_we (ret_we), .ret_dest (ret_dest),
      .cxl_we (cxl_we), .cxl_dest (cxl_dest),
      .rp_data (rp_data), .ds_stall (ds_stall), .sb_err (sb_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      rp_en = '0; rp_addr = '0; rf_rdata = '0;
      fwd_we = '0; fwd_dest = '0; fwd_ok = '0; fwd_data = '0;
      iss_fire = 0; iss_we = 0; iss_dest = '0;
      ret_we = 0; ret_dest = '0; cxl_we = 0; cxl_dest = '0;
   endtask

   task automatic set_rp(input int p, input logic en, input logic [4:0] a, input logic [DATA_W-1:0] d);
      rp_en[p] = en; rp_addr[p*5 +: 5] = a; rf_rdata[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_fwd(input int i, input logic we, input logic [4:0] a, input logic ok,
                          input logic [DATA_W-1:0] d);
      fwd_we[i] = we; fwd_dest[i*5 +: 5] = a; fwd_ok[i] = ok; fwd_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic set_iss(input logic fire, input logic we, input logic [4:0] a);
      iss_fire = fire; iss_we = we; iss_dest = a;
   endtask

   // Reference: read resolves to the youngest matching bypass, else the regfile;
   // a pending writer with nothing on the bypass blocks decode.
   function automatic void model_outputs();
      logic [4:0]        a;
      logic [DATA_W-1:0] rf;
      int                first;
      exp_stall = 0;
      for (int p = 0; p < NUM_RP; p++) begin
         a  = rp_addr[p*5 +: 5];
         rf = rf_rdata[p*DATA_W +: DATA_W];
         first = -1;
         for (int i = 0; i < NUM_FWD; i++)
            if (first < 0 && fwd_we[i] && fwd_dest[i*5 +: 5] == a) first = i;
         if (!rp_en[p]) exp_data[p] = rf;
         else if (a == 0) exp_data[p] = '0;
         else if (first >= 0) begin
            exp_data[p] = fwd_data[first*DATA_W +: DATA_W];
            if (!fwd_ok[first]) exp_stall = 1;
         end else begin
            exp_data[p] = rf;
            if (cnt_m[a] != 0 && !(ret_we && ret_dest == a)) exp_stall = 1;
         end
      end
      if (iss_we && iss_dest != 0 && cnt_m[iss_dest] == MAXC) exp_stall = 1;
   endfunction

   function automatic void model_clock();
      int n;
      if (reset) begin
         for (int r = 0; r < 32; r++) cnt_m[r] = 0;
         err_m = 0;
      end else begin
         if (iss_fire && exp_stall) err_m = 1;
         for (int r = 1; r < 32; r++) begin
            n = cnt_m[r] + ((iss_fire && iss_we && iss_dest == r) ? 1 : 0)
                         - ((ret_we && ret_dest == r) ? 1 : 0)
                         - ((cxl_we && cxl_dest == r) ? 1 : 0);
            if (n < 0) begin n = 0; err_m = 1; end
            if (n > MAXC) begin n = MAXC; err_m = 1; end
            cnt_m[r] = n;
         end
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      idle();
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      set_rp(0, 1, 5'd5, 32'h11);
      set_rp(1, 1, 5'd3, 32'h22);
      #1;
      checks++; if (rp_data[0 +: DATA_W] !== 32'h11) begin failures++; $display("FAIL reset_p0 got=%h exp=%h", rp_data[0 +: DATA_W], 32'h11); end
      checks++; if (rp_data[DATA_W +: DATA_W] !== 32'h22) begin failures++; $display("FAIL reset_p1 got=%h exp=%h", rp_data[DATA_W +: DATA_W], 32'h22); end
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ds_stall); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sb_err); end
      @(posedge clk);
   endtask

   task automatic test_fwd_priority();
      @(negedge clk);
      idle();
      set_rp(0, 1, 5'd5, 32'hDEAD);
      set_rp(1, 1, 5'd6, 32'hBEEF);
      set_fwd(0, 1, 5'd5, 1, 32'hA);
      set_fwd(1, 1, 5'd6, 1, 32'hB);
      set_fwd(2, 1, 5'd5, 1, 32'hC);
      #1;
      checks++; if (rp_data[0 +: DATA_W] !== 32'hA) begin failures++; $display("FAIL fwd_youngest got=%h exp=%h", rp_data[0 +: DATA_W], 32'hA); end
      checks++; if (rp_data[DATA_W +: DATA_W] !== 32'hB) begin failures++; $display("FAIL fwd_ms got=%h exp=%h", rp_data[DATA_W +: DATA_W], 32'hB); end
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%b exp=0", ds_stall); end
      set_rp(1, 1, 5'd0, 32'h55);
      set_fwd(1, 1, 5'd0, 0, 32'h66);
      set_rp(0, 0, 5'd5, 32'h77);
      #1;
      checks++; if (rp_data[DATA_W +: DATA_W] !== 32'h0) begin failures++; $display("FAIL r0_zero got=%h exp=0", rp_data[DATA_W +: DATA_W]); end
      checks++; if (rp_data[0 +: DATA_W] !== 32'h77) begin failures++; $display("FAIL en_off_rf got=%h exp=%h", rp_data[0 +: DATA_W], 32'h77); end
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b exp=0", ds_stall); end
      @(posedge clk);
   endtask

   task automatic test_load_stall();
      @(negedge clk);
      idle();
      set_rp(0, 1, 5'd5, 32'h0);
      set_fwd(0, 1, 5'd5, 0, 32'h1);
      set_fwd(1, 1, 5'd5, 1, 32'h2);
      #1;
      checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", ds_stall); end
      @(posedge clk);
      @(negedge clk);
      fwd_ok[0] = 1;
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL load_done got=%b exp=0", ds_stall); end
      checks++; if (rp_data[0 +: DATA_W] !== 32'h1) begin failures++; $display("FAIL load_data got=%h exp=1", rp_data[0 +: DATA_W]); end
      @(posedge clk);
   endtask

   task automatic test_div_ret();
      @(negedge clk);
      idle();
      set_iss(1, 1, 5'd7);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL div_issue got=%b exp=0", ds_stall); end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         idle();
         set_rp(0, 1, 5'd7, 32'h77);
         #1;
         checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL div_wait%0d got=%b exp=1", k, ds_stall); end
         @(posedge clk);
      end
      @(negedge clk);
      ret_we = 1; ret_dest = 5'd7;
      set_fwd(2, 1, 5'd7, 1, 32'h700);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL div_ret_stall got=%b exp=0", ds_stall); end
      checks++; if (rp_data[0 +: DATA_W] !== 32'h700) begin failures++; $display("FAIL div_ret_data got=%h exp=%h", rp_data[0 +: DATA_W], 32'h700); end
      @(posedge clk);
      @(negedge clk);
      idle();
      set_rp(0, 1, 5'd7, 32'h77);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL div_cleared got=%b exp=0", ds_stall); end
      checks++; if (rp_data[0 +: DATA_W] !== 32'h77) begin failures++; $display("FAIL div_rf got=%h exp=%h", rp_data[0 +: DATA_W], 32'h77); end
      @(posedge clk);
   endtask

   task automatic test_inc_dec();
      @(negedge clk);
      idle();
      set_iss(1, 1, 5'd9);
      @(posedge clk);
      @(negedge clk);
      set_iss(1, 1, 5'd9);
      ret_we = 1; ret_dest = 5'd9;
      @(posedge clk);
      @(negedge clk);
      idle();
      set_rp(0, 1, 5'd9, 32'h9);
      cxl_we = 1; cxl_dest = 5'd9;
      #1;
      checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL net_hold got=%b exp=1", ds_stall); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL cxl_clear got=%b exp=0", ds_stall); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL pre_under got=%b exp=0", sb_err); end
      @(posedge clk);
      @(negedge clk);
      idle();
      #1;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", sb_err); end
      set_rp(0, 1, 5'd9, 32'h9);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL under_clamp got=%b exp=0", ds_stall); end
      @(posedge clk);
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_iss(1, 1, 5'd4);
         #1;
         checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL sat_fill%0d got=%b exp=0", k, ds_stall); end
         @(posedge clk);
         @(negedge clk);
      end
      set_iss(0, 1, 5'd4);
      #1;
      checks++; if (ds_stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%b exp=1", ds_stall); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL sat_noerr got=%b exp=0", sb_err); end
      set_iss(1, 1, 5'd4);
      @(posedge clk);
      @(negedge clk);
      set_iss(0, 0, 5'd0);
      #1;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", sb_err); end
      reset = 1;
      set_iss(1, 1, 5'd4);
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      idle();
      set_rp(1, 1, 5'd4, 32'h4);
      set_iss(0, 1, 5'd4);
      #1;
      checks++; if (ds_stall !== 1'b0) begin failures++; $display("FAIL rst_clear got=%b exp=0", ds_stall); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", sb_err); end
      @(posedge clk);
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      err_m = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 39) == 0);
         for (int p = 0; p < NUM_RP; p++)
            set_rp(p, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
         for (int i = 0; i < NUM_FWD; i++)
            set_fwd(i, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), $urandom);
         set_iss(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
         ret_we = ($urandom_range(0, 4) == 0); ret_dest = 5'($urandom_range(0, 7));
         cxl_we = ($urandom_range(0, 7) == 0); cxl_dest = 5'($urandom_range(0, 7));
         #1;
         model_outputs();
         for (int p = 0; p < NUM_RP; p++) begin
            checks++;
            if (rp_data[p*DATA_W +: DATA_W] !== exp_data[p]) begin
               failures++;
               $display("FAIL rnd_data c=%0d p=%0d got=%h exp=%h", c, p, rp_data[p*DATA_W +: DATA_W], exp_data[p]);
            end
         end
         checks++; if (ds_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, ds_stall, exp_stall); end
         checks++; if (sb_err !== err_m) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, sb_err, err_m); end
         model_clock();
         @(posedge clk);
      end
      @(negedge clk);
      reset = 0;
      idle();
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_fwd_priority();
      test_load_stall();
      test_div_ret();
      test_inc_dec();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
